lcd_pixel_feed: RTL

LCD_PIXEL_FEED -- requirements
Module: lcd_pixel_feed

---
 rtl/lcd_pixel_feed.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_pixel_feed.sv
// RGB565 frame-buffer FIFO to LCD panel feeder; optional colour-bar generator under macro LCD_COLORBAR_EN.
// Latency: 2 rgb_clk cycles from timing input to lcd_*; no backpressure, an empty FIFO yields black pixels.
module lcd_pixel_feed #(
  parameter int H_ACTIVE = 800,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        rgb_clk,
  input  logic        rst_n,
  input  logic        rgb_hs_i,
  input  logic        rgb_vs_i,
  input  logic        rgb_de_i,
`ifdef LCD_COLORBAR_EN
  input  logic        bar_en,
`endif
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        frame_req,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        underflow,
  output logic        line_err,
  output logic [15:0] underflow_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, ACTIVE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        vs_q;
  logic        vs_start;
  logic        frame_req_q;
  logic        active;
  logic        src_fifo;
  logic        uf_event;

  logic        hs1_q, vs1_q, de1_q, rd1_q;
  logic        hs2_q, vs2_q, de2_q;
  logic [15:0] pix_d, pix2_q;

  logic [11:0] line_cnt_q, line_cnt_d;
  logic        line_err_set;
  logic        underflow_q, underflow_d;
  logic        line_err_q, line_err_d;
  logic [15:0] uf_cnt_q, uf_cnt_d;

`ifdef LCD_COLORBAR_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

  logic        bar_on;
  logic        bar1_q;
  logic [15:0] barpix1_q, barpix_d;
  logic [11:0] bar_pos;
  logic [2:0]  bar_idx;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction
`endif

  assign vs_start = (vs_q != VS_POL) && (rgb_vs_i == VS_POL);

  always_ff @(posedge rgb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_start) state_d = SYNC;
      SYNC:    if (rgb_vs_i != VS_POL) state_d = ACTIVE;
      ACTIVE:  if (vs_start) state_d = SYNC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == ACTIVE);
`ifdef LCD_COLORBAR_EN
    bar_on   = active & bar_en & rgb_de_i;
    src_fifo = active & ~bar_en;
`else
    src_fifo = active;
`endif
    fifo_rd_en = src_fifo & rgb_de_i & ~fifo_empty;
    uf_event   = src_fifo & rgb_de_i & fifo_empty;
  end

  always_comb begin
    line_cnt_d   = line_cnt_q;
    line_err_set = 1'b0;
    if (!active) begin
      line_cnt_d = 12'd0;
    end else if (de1_q && !rgb_de_i) begin
      line_cnt_d   = 12'd0;
      line_err_set = (line_cnt_q != 12'(H_ACTIVE));
    end else if (rgb_de_i) begin
      line_cnt_d = line_cnt_q + 12'd1;
    end
  end

  // Status restarts on the edge that raises frame_req; an event in that same cycle survives.
  always_comb begin
    if (vs_start) begin
      underflow_d = uf_event;
      uf_cnt_d    = {15'd0, uf_event};
      line_err_d  = line_err_set;
    end else begin
      underflow_d = underflow_q | uf_event;
      uf_cnt_d    = (uf_event && uf_cnt_q != 16'hFFFF) ? uf_cnt_q + 16'd1 : uf_cnt_q;
      line_err_d  = line_err_q | line_err_set;
    end
  end

`ifdef LCD_COLORBAR_EN
  always_comb begin
    bar_pos  = line_cnt_q / 12'(BAR_W);
    bar_idx  = (bar_pos > 12'd7) ? 3'd7 : bar_pos[2:0];
    barpix_d = bar_on ? bar_color(bar_idx) : 16'h0000;
  end
`endif

  // fifo_rd_data is only trusted in the cycle after a read strobe.
  always_comb begin
    pix_d = rd1_q ? fifo_rd_data : 16'h0000;
`ifdef LCD_COLORBAR_EN
    if (bar1_q) pix_d = barpix1_q;
`endif
  end

  always_ff @(posedge rgb_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= VS_POL;
      frame_req_q <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= ~VS_POL;
      de1_q       <= 1'b0;
      rd1_q       <= 1'b0;
      hs2_q       <= 1'b1;
      vs2_q       <= ~VS_POL;
      de2_q       <= 1'b0;
      pix2_q      <= 16'h0000;
      line_cnt_q  <= 12'd0;
      underflow_q <= 1'b0;
      line_err_q  <= 1'b0;
      uf_cnt_q    <= 16'd0;
    end else begin
      vs_q        <= rgb_vs_i;
      frame_req_q <= vs_start;
      hs1_q       <= rgb_hs_i;
      vs1_q       <= rgb_vs_i;
      de1_q       <= rgb_de_i;
      rd1_q       <= fifo_rd_en;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      de2_q       <= de1_q;
      pix2_q      <= pix_d;
      line_cnt_q  <= line_cnt_d;
      underflow_q <= underflow_d;
      line_err_q  <= line_err_d;
      uf_cnt_q    <= uf_cnt_d;
    end
  end

`ifdef LCD_COLORBAR_EN
  always_ff @(posedge rgb_clk or negedge rst_n) begin
    if (!rst_n) begin
      bar1_q    <= 1'b0;
      barpix1_q <= 16'h0000;
    end else begin
      bar1_q    <= bar_on;
      barpix1_q <= barpix_d;
    end
  end
`endif

  assign frame_req     = frame_req_q;
  assign lcd_hs        = hs2_q;
  assign lcd_vs        = vs2_q;
  assign lcd_de        = de2_q;
  assign lcd_r         = pix2_q[15:11];
  assign lcd_g         = pix2_q[10:5];
  assign lcd_b         = pix2_q[4:0];
  assign underflow     = underflow_q;
  assign line_err      = line_err_q;
  assign underflow_cnt = uf_cnt_q;

endmodule
